dbn_hidden_sampler: RTL and testbench

//  Consumes the 16-lane accumulated sum vector (16 x 32b) that the matrix_multi

---
 rtl/dbn_hidden_sampler_pkg.sv | 49 ++++
 rtl/dbn_hidden_sampler_plan_sigmoid.sv | 38 +++
 rtl/dbn_hidden_sampler.sv | 130 +++++++++++++
 tb/tb_dbn_hidden_sampler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dbn_hidden_sampler_pkg.sv
// Shared definitions for the DBN hidden-unit sampler: FSM state encoding,
// lane geometry, PLAN sigmoid breakpoints/offsets (Q.8 input, Q0.16 output),
// LFSR parameters and two small arithmetic helpers.
package dbn_pkg;

  localparam int NUM_N  = 16;
  localparam int SUM_W  = 32;
  localparam int FRAC_W = 8;
  localparam int PROB_W = 16;
  localparam int CNT_W  = $clog2(NUM_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BIAS = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_e;

  // PLAN breakpoints on |x| (Q.8) and the offsets of each linear segment.
  localparam int PLAN_BP_LO   = 256;
  localparam int PLAN_BP_MID  = 608;
  localparam int PLAN_BP_HI   = 1280;
  localparam int PLAN_OFF_LO  = 32768;
  localparam int PLAN_OFF_MID = 40960;
  localparam int PLAN_OFF_HI  = 55296;

  localparam logic [PROB_W-1:0] PROB_HALF = 16'h8000;

  localparam int                LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

  localparam logic signed [SUM_W-1:0] SUM_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [SUM_W-1:0] SUM_MIN = 32'sh8000_0000;

  // Signed add clamped to the 32-bit range.
  function automatic logic signed [SUM_W-1:0] sat_add(input logic signed [SUM_W-1:0] a,
                                                     input logic signed [SUM_W-1:0] b);
    logic [SUM_W:0] s;
    s = {a[SUM_W-1], a} + {b[SUM_W-1], b};
    if (s[SUM_W] != s[SUM_W-1]) return s[SUM_W] ? SUM_MIN : SUM_MAX;
    return s[SUM_W-1:0];
  endfunction

  // Galois step: shift right, fold the mask in when a one falls out.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/dbn_hidden_sampler_plan_sigmoid.sv
// plan_sigmoid: combinational PLAN approximation of the logistic function.
// Ports:
//   x    in  signed [31:0]  pre-activation, Q24.8
//   prob out [15:0]         sigmoid(x), unsigned Q0.16
module plan_sigmoid
  import dbn_pkg::*;
(
  input  logic signed [SUM_W-1:0]  x,
  output logic        [PROB_W-1:0] prob
);

  logic [SUM_W-1:0]  a;
  logic [PROB_W:0]   t;
  logic [PROB_W-1:0] y;

  // |x|; the most negative value has no positive twin, so clamp it.
  assign a = !x[SUM_W-1]  ? x :
             (x == SUM_MIN) ? SUM_MAX : SUM_W'(-x);

  // Each segment only needs the low bits of a that can be set below its
  // upper breakpoint; t carries one extra bit so the top segment can clamp.
  always_comb begin
    t = '0;
    if (a >= SUM_W'(PLAN_BP_HI))
      t = 17'h0_FFFF;
    else if (a >= SUM_W'(PLAN_BP_MID))
      t = {3'b0, a[10:0], 3'b0} + 17'(PLAN_OFF_HI);
    else if (a >= SUM_W'(PLAN_BP_LO))
      t = {2'b0, a[9:0], 5'b0} + 17'(PLAN_OFF_MID);
    else
      t = {3'b0, a[7:0], 6'b0} + 17'(PLAN_OFF_LO);
    y = t[PROB_W] ? 16'hFFFF : t[PROB_W-1:0];
  end

  // sigmoid(-x) = 1 - sigmoid(x); 0xFFFF - y is a bitwise inversion.
  assign prob = x[SUM_W-1] ? ~y : y;

endmodule

// File: rtl/dbn_hidden_sampler.sv
// dbn_hidden_sampler: adds a per-lane bias to a 16-lane accumulated sum,
// applies the PLAN sigmoid one neuron per cycle and emits binary hidden
// units (threshold or LFSR-stochastic) plus the probability vector.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input handshake for sum_in, bias_in, sample_en
//   sum_in, bias_in       16 x 32b signed Q.8 lanes, lane k at [32k+31:32k]
//   sample_en             1 = stochastic, 0 = threshold at 0x8000
//   out_valid / out_ready output handshake; outputs held while waiting
//   hidden_out            bit k = hidden unit k
//   prob_out              16 x 16b Q0.16, lane k at [16k+15:16k]
module dbn_hidden_sampler
  import dbn_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_N*SUM_W-1:0]  sum_in,
  input  logic [NUM_N*SUM_W-1:0]  bias_in,
  input  logic                    sample_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_N-1:0]        hidden_out,
  output logic [NUM_N*PROB_W-1:0] prob_out
);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [LFSR_W-1:0]        lfsr_q, lfsr_d;
  logic                     sample_en_q, sample_en_d;
  logic [NUM_N-1:0]         hidden_q, hidden_d;
  logic [NUM_N*PROB_W-1:0]  prob_q, prob_d;
  logic signed [SUM_W-1:0]  acc_q  [NUM_N];
  logic signed [SUM_W-1:0]  acc_d  [NUM_N];
  logic signed [SUM_W-1:0]  bias_q [NUM_N];
  logic signed [SUM_W-1:0]  bias_d [NUM_N];

  logic signed [SUM_W-1:0]  x_sel;
  logic [PROB_W-1:0]        prob_k;
  logic                     hid_k;

  // One sigmoid shared by all lanes, steered by the neuron counter.
  assign x_sel = acc_q[cnt_q];

  plan_sigmoid u_plan_sigmoid (
    .x    (x_sel),
    .prob (prob_k)
  );

  assign hid_k = sample_en_q ? (prob_k >= lfsr_q) : (prob_k >= PROB_HALF);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    sample_en_d = sample_en_q;
    hidden_d    = hidden_q;
    prob_d      = prob_q;
    acc_d       = acc_q;
    bias_d      = bias_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int k = 0; k < NUM_N; k++) begin
            acc_d[k]  = sum_in[k*SUM_W +: SUM_W];
            bias_d[k] = bias_in[k*SUM_W +: SUM_W];
          end
          sample_en_d = sample_en;
          cnt_d       = '0;
          state_d     = BIAS;
        end
      end
      BIAS: begin
        // The biased value overwrites the sum in place.
        for (int k = 0; k < NUM_N; k++) acc_d[k] = sat_add(acc_q[k], bias_q[k]);
        state_d = EVAL;
      end
      EVAL: begin
        hidden_d[cnt_q]                 = hid_k;
        prob_d[cnt_q*PROB_W +: PROB_W]  = prob_k;
        lfsr_d                          = lfsr_step(lfsr_q);
        cnt_d                           = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_N - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      sample_en_q <= 1'b0;
      hidden_q    <= '0;
      prob_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      sample_en_q <= sample_en_d;
      hidden_q    <= hidden_d;
      prob_q      <= prob_d;
    end
  end

  // NOTE: the lane storage is deliberately not reset; it is always written
  // on accept before it is read, so a reset would only add fan-out.
  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    bias_q <= bias_d;
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign hidden_out = hidden_q;
  assign prob_out   = prob_q;

endmodule

// File: tb/tb_dbn_hidden_sampler.sv
module tb_dbn_hidden_sampler;

  localparam logic [15:0] SEED = 16'hACE1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] sum_in;
  logic [511:0] bias_in;
  logic         sample_en;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  hidden_out;
  logic [255:0] prob_out;

  dbn_hidden_sampler #(.LFSR_SEED(SEED)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum_in     (sum_in),
    .bias_in    (bias_in),
    .sample_en  (sample_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .hidden_out (hidden_out),
    .prob_out   (prob_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]  hid;
    logic [255:0] prob;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc;
  logic [15:0]  m_lfsr = SEED;
  logic [511:0] v_sum, v_bias;
  logic         v_se;
  logic [15:0]  last_hid;
  logic [255:0] last_prob;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint m_sat(input longint s);
    if (s > 64'sd2147483647) return 64'sd2147483647;
    if (s < -64'sd2147483648) return -64'sd2147483648;
    return s;
  endfunction

  function automatic logic [15:0] m_sig(input longint x);
    longint a, y;
    a = (x < 0) ? -x : x;
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    if (a >= 1280)     y = 65535;
    else if (a >= 608) begin
      y = a * 8 + 55296;
      if (y > 65535) y = 65535;
    end
    else if (a >= 256) y = a * 32 + 40960;
    else               y = a * 64 + 32768;
    if (x < 0) y = 65535 - y;
    return 16'(y);
  endfunction

  function automatic logic [15:0] m_step(input logic [15:0] v);
    logic [15:0] n;
    n = {1'b0, v[15:1]};
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic push_expected();
    exp_t   e;
    longint s, b;
    logic [15:0] p;
    e = '0;
    for (int k = 0; k < 16; k++) begin
      s = longint'($signed(v_sum[k*32 +: 32]));
      b = longint'($signed(v_bias[k*32 +: 32]));
      p = m_sig(m_sat(s + b));
      e.prob[k*16 +: 16] = p;
      e.hid[k] = v_se ? (p >= m_lfsr) : (p >= 16'h8000);
      m_lfsr = m_step(m_lfsr);
    end
    sb.push_back(e);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_lane(input int k, input logic [31:0] s, input logic [31:0] b);
    v_sum[k*32 +: 32]  = s;
    v_bias[k*32 +: 32] = b;
  endtask

  task automatic rand_vec(input logic se);
    for (int k = 0; k < 16; k++)
      set_lane(k, 32'($signed($urandom_range(0, 3000)) - 1500),
                  32'($signed($urandom_range(0, 400)) - 200));
    v_se = se;
  endtask

  task automatic send();
    int w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_before_send", 256'(in_ready), 256'(1));
    sum_in    = v_sum;
    bias_in   = v_bias;
    sample_en = v_se;
    in_valid  = 1'b1;
    push_expected();
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
  endtask

  task automatic receive(input int hold, input string tag);
    exp_t e;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    if (!out_valid) begin
      check({tag, "_timeout"}, 256'(out_valid), 256'(1));
      return;
    end
    check({tag, "_latency"}, 256'(cyc), 256'(18));
    e = sb.pop_front();
    last_hid  = hidden_out;
    last_prob = prob_out;
    check({tag, "_hidden"}, 256'(hidden_out), 256'(e.hid));
    check({tag, "_prob"}, prob_out, e.prob);
    if (hold > 0) begin
      rand_vec(1'b1);
      sum_in   = v_sum;
      bias_in  = v_bias;
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, 256'(out_valid), 256'(1));
        check({tag, "_hold_ready"}, 256'(in_ready), 256'(0));
        check({tag, "_hold_hidden"}, 256'(hidden_out), 256'(e.hid));
        check({tag, "_hold_prob"}, prob_out, e.prob);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ready_after"}, 256'(in_ready), 256'(1));
    check({tag, "_valid_after"}, 256'(out_valid), 256'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sample_en = 1'b0;
    sum_in = '0; bias_in = '0; v_sum = '0; v_bias = '0; v_se = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 256'(in_ready), 256'(1));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_hidden", 256'(hidden_out), 256'(0));
    check("rst_prob", prob_out, 256'(0));
    check("rst_lfsr", 256'(dut.lfsr_q), 256'(SEED));

    // 1: zero input, threshold mode
    v_sum = '0; v_bias = '0; v_se = 1'b0;
    send();
    receive(0, "zero");
    check("zero_hidden_const", 256'(last_hid), 256'(16'hFFFF));
    check("zero_prob_lane0", 256'(last_prob[15:0]), 256'(16'h8000));

    // 2: segment breakpoints
    set_lane(0, 256, 0);   set_lane(1, -256, 0);  set_lane(2, 1280, 0);
    set_lane(3, -1280, 0); set_lane(4, 608, 0);   set_lane(5, 100, 0);
    set_lane(6, -700, 0);  set_lane(7, 300, 0);   set_lane(8, 1279, 0);
    set_lane(9, -1000, 0); set_lane(10, 0, 0);    set_lane(11, 607, 0);
    set_lane(12, -255, 0); set_lane(13, 5000, 0); set_lane(14, -608, 0);
    set_lane(15, 255, 0);
    v_se = 1'b0;
    send();
    receive(0, "bp");
    check("bp_256", 256'(last_prob[15:0]), 256'(16'hC000));
    check("bp_m256", 256'(last_prob[31:16]), 256'(16'h3FFF));
    check("bp_1280", 256'(last_prob[47:32]), 256'(16'hFFFF));
    check("bp_m1280", 256'(last_prob[63:48]), 256'(16'h0000));
    check("bp_608", 256'(last_prob[79:64]), 256'(16'hEB00));

    // 3: saturation of sum + bias
    rand_vec(1'b0);
    set_lane(0, 32'h7FFF_FFF0, 32'h0000_0100);
    set_lane(1, 32'h8000_0010, 32'hFFFF_FF00);
    send();
    receive(0, "sat");
    check("sat_pos", 256'(last_prob[15:0]), 256'(16'hFFFF));
    check("sat_neg", 256'(last_prob[31:16]), 256'(16'h0000));

    // 4: back-pressure in DONE with a stray in_valid
    rand_vec(1'b0);
    send();
    receive(10, "hold");

    // 5: stochastic mode, LFSR continues across vectors
    for (int v = 0; v < 2; v++) begin
      rand_vec(1'b1);
      set_lane(2, 2000, 0);
      set_lane(3, -2000, 0);
      send();
      receive(0, "stoch");
      check("stoch_sat_one", 256'(last_hid[2]), 256'(1));
      check("stoch_sat_zero", 256'(last_hid[3]), 256'(0));
    end

    // 6: reset during EVAL at neuron 7 aborts the vector
    rand_vec(1'b1);
    send();
    while (cyc < 9) begin
      @(posedge clk); #1; cyc++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_back());
    m_lfsr = SEED;
    check("abort_out_valid", 256'(out_valid), 256'(0));
    check("abort_in_ready", 256'(in_ready), 256'(1));
    check("abort_lfsr", 256'(dut.lfsr_q), 256'(SEED));
    check("abort_prob", prob_out, 256'(0));
    rand_vec(1'b1);
    send();
    receive(0, "post_abort");

    check("sb_empty", 256'(sb.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
